// File: rtl/branch_resolver.sv
// Branch resolution FSM: steers the compare unit, waits for its flags and the
// delay-slot issue, then emits a one-cycle PC redirect for taken branches.
module branch_resolver #(
   parameter int CMP_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        br_valid,
   output logic        br_ready,
   input  logic [2:0]  br_op,
   input  logic [31:0] br_pc,
   input  logic [15:0] br_offset,
   output logic        cmp_signed,
   input  logic        cmp_valid,
   input  logic        cmp_equal,
   input  logic        cmp_small,
   input  logic        slot_done,
   input  logic        flush,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        err,
   output logic        busy
);

   localparam int CNT_W = (CMP_TIMEOUT < 2) ? 1 : $clog2(CMP_TIMEOUT + 1);

   localparam logic [2:0] OP_BEQ  = 3'b000;
   localparam logic [2:0] OP_BNE  = 3'b001;
   localparam logic [2:0] OP_BLT  = 3'b010;
   localparam logic [2:0] OP_BGE  = 3'b011;
   localparam logic [2:0] OP_BLTU = 3'b100;
   localparam logic [2:0] OP_BGEU = 3'b101;
   localparam logic [2:0] OP_J    = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_CMP,
      ST_WAIT_SLOT,
      ST_REDIRECT
   } state_t;

   function automatic logic eval_taken(input logic [2:0] op,
                                       input logic       eq,
                                       input logic       lt);
      logic t;
      case (op)
         OP_BEQ:  t = eq;
         OP_BNE:  t = ~eq;
         OP_BLT:  t = lt;
         OP_BGE:  t = ~lt;
         OP_BLTU: t = lt;
         OP_BGEU: t = ~lt;
         OP_J:    t = 1'b1;
         default: t = 1'b0;
      endcase
      eval_taken = t;
   endfunction

   function automatic logic is_signed_op(input logic [2:0] op);
      is_signed_op = (op == OP_BLT) || (op == OP_BGE);
   endfunction

   state_t            state;
   state_t            state_nxt;
   logic [2:0]        op_q;
   logic [31:0]       target_q;
   logic              taken_q;
   logic              taken_nxt;
   logic              slot_seen_q;
   logic              slot_seen_nxt;
   logic [CNT_W-1:0]  tmo_cnt;
   logic [CNT_W-1:0]  tmo_cnt_nxt;
   logic              timeout;
   logic              accept;
   logic              cmp_taken;
   logic              slot_now;
   logic              tmo_last;
   logic              cmp_signed_nxt;
   logic              redirect_nxt;
   logic [31:0]       redirect_pc_nxt;
   logic              err_nxt;
   logic signed [31:0] off_bytes;
   logic [31:0]       target_calc;

   // Word offset scaled to bytes; the sum wraps silently modulo 2^32.
   assign off_bytes   = {{14{br_offset[15]}}, br_offset, 2'b00};
   assign target_calc = br_pc + 32'd4 + $unsigned(off_bytes);

   assign accept    = br_valid & br_ready;
   assign cmp_taken = eval_taken(op_q, cmp_equal, cmp_small);
   assign slot_now  = slot_seen_q | slot_done;
   assign tmo_last  = (tmo_cnt == CNT_W'(CMP_TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      timeout       = 1'b0;
      taken_nxt     = taken_q;
      slot_seen_nxt = slot_seen_q;
      tmo_cnt_nxt   = tmo_cnt;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt     = (br_op == OP_J) ? ST_WAIT_SLOT : ST_WAIT_CMP;
               taken_nxt     = (br_op == OP_J);
               slot_seen_nxt = 1'b0;
               tmo_cnt_nxt   = '0;
            end
         end
         ST_WAIT_CMP: begin
            if (cmp_valid) begin
               taken_nxt = cmp_taken;
               if (slot_now) begin
                  state_nxt = cmp_taken ? ST_REDIRECT : ST_IDLE;
               end else begin
                  state_nxt = ST_WAIT_SLOT;
               end
            end else begin
               slot_seen_nxt = slot_now;
               tmo_cnt_nxt   = tmo_cnt + CNT_W'(1);
               if (tmo_last) begin
                  state_nxt = ST_IDLE;
                  timeout   = 1'b1;
               end
            end
         end
         ST_WAIT_SLOT: begin
            if (slot_done) begin
               state_nxt = taken_q ? ST_REDIRECT : ST_IDLE;
            end
         end
         ST_REDIRECT: state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
      // An abort overrides every resolution or timeout in the same cycle.
      if (flush) begin
         state_nxt = ST_IDLE;
         timeout   = 1'b0;
      end
   end

   always_comb begin
      br_ready        = (state == ST_IDLE) & ~flush;
      busy            = (state != ST_IDLE);
      redirect_nxt    = (state_nxt == ST_REDIRECT);
      redirect_pc_nxt = redirect_nxt ? target_q : 32'd0;
      err_nxt         = timeout;
      if (state_nxt == ST_IDLE) begin
         cmp_signed_nxt = 1'b0;
      end else if (accept) begin
         cmp_signed_nxt = is_signed_op(br_op);
      end else begin
         cmp_signed_nxt = cmp_signed;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         taken_q     <= 1'b0;
         slot_seen_q <= 1'b0;
         tmo_cnt     <= '0;
         cmp_signed  <= 1'b0;
         redirect    <= 1'b0;
         redirect_pc <= 32'd0;
         err         <= 1'b0;
      end else begin
         taken_q     <= taken_nxt;
         slot_seen_q <= slot_seen_nxt;
         tmo_cnt     <= tmo_cnt_nxt;
         cmp_signed  <= cmp_signed_nxt;
         redirect    <= redirect_nxt;
         redirect_pc <= redirect_pc_nxt;
         err         <= err_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         op_q     <= br_op;
         target_q <= target_calc;
      end
   end

   // Redirect and timeout come from mutually exclusive transitions.
   assert property (@(posedge clk) disable iff (!rst_n) !(redirect && err));
   assert property (@(posedge clk) disable iff (!rst_n) br_ready |-> !busy);

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Sequential branch-resolution unit sitting downstream of the ALU compare path. It accepts a branch from decode and drives the signed/unsigned select to the compare unit. It then consumes the EQUAL/SMALL flags that unit returns and waits for the MIPS delay-slot instruction to issue. Finally it emits a one-cycle PC redirect for taken branches, with timeout and flush handling.

## Interface
- CMP_TIMEOUT, 15: max cycles spent in WAIT_CMP before abort (≥1)
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  asynchronous, active-low reset
- BR_VALID  in  1  branch request valid
- BR_READY  out  1  request accepted when BR_VALID & BR_READY
- BR_OP  in  3  000 BEQ, 001 BNE, 010 BLT, 011 BGE, 100 BLTU, 101 BGEU, 110 J, 111 reserved (never taken)
- BR_PC  in  32  PC of branch instruction
- BR_OFFSET  in  16  signed word offset
- CMP_SIGNED  out  1  signed-compare select to compare unit
- CMP_VALID  in  1  EQUAL/SMALL valid this cycle
- EQUAL  in  1  A == B
- SMALL  in  1  A < B (per CMP_SIGNED)
- SLOT_DONE  in  1  delay-slot instruction issued (pulse)
- FLUSH  in  1  synchronous abort
- REDIRECT  out  1  one-cycle taken-branch pulse
- REDIRECT_PC  out  32  target, valid with REDIRECT
- ERR  out  1  one-cycle compare-timeout pulse
- BUSY  out  1  state != IDLE

## Operation
- States: IDLE, WAIT_CMP, WAIT_SLOT, REDIRECT.
- Reset values: state IDLE, REDIRECT 0, REDIRECT_PC 0, ERR 0, CMP_SIGNED 0, BUSY 0.
- BR_READY = (state==IDLE) & ~FLUSH. It is 1 after reset.
- Accept action: latch op.
- Accept action: compute target = BR_PC + 4 + (sext(BR_OFFSET) << 2), modulo 2^32; wrap-around is silent.
- Accept action: CMP_SIGNED <= 1 for BLT/BGE, else 0; held until return to IDLE.
- Accept action: clear slot_seen and the timeout counter.
- Next state after accept: WAIT_SLOT for J; WAIT_CMP otherwise.
- WAIT_CMP, on CMP_VALID: taken is computed from the table below.
  - BEQ=EQUAL, BNE=~EQUAL.
  - BLT/BLTU=SMALL, BGE/BGEU=~SMALL.
  - J=1, reserved=0.
- WAIT_CMP, SLOT_DONE already seen (slot_seen set or SLOT_DONE this cycle): go to REDIRECT if taken, else IDLE.
- WAIT_CMP, slot not yet seen: latch taken and go to WAIT_SLOT.
- WAIT_CMP without CMP_VALID: SLOT_DONE sets slot_seen.
- WAIT_CMP without CMP_VALID: the counter increments. After CMP_TIMEOUT WAIT_CMP cycles with no CMP_VALID, go to IDLE and pulse ERR. CMP_VALID on the last allowed cycle wins over timeout.
- WAIT_SLOT: on SLOT_DONE go to REDIRECT if taken, else IDLE. There is no timeout in WAIT_SLOT.
- REDIRECT: REDIRECT=1 and REDIRECT_PC=target for exactly one cycle, then IDLE.
- FLUSH: in any state, next state IDLE. No REDIRECT or ERR is generated by the aborted branch.
  - A REDIRECT pulse already being driven is not retracted.
  - FLUSH with BR_VALID in IDLE: the request is not accepted.
  - FLUSH beats CMP_VALID, SLOT_DONE and timeout in the same cycle.
- CMP_VALID or SLOT_DONE in IDLE or REDIRECT: ignored.
- Reset mid-operation: immediate return to reset values; no pulse is emitted.

## Timing
- Registered outputs: REDIRECT, REDIRECT_PC, ERR, CMP_SIGNED.
- Combinational outputs: BR_READY, BUSY.
- Best case: accept in cycle T; CMP_VALID and SLOT_DONE in T+1; REDIRECT high in T+2; BR_READY high in T+3.
- Not-taken best case: accept T, resolve T+1, BR_READY high in T+2.
- J: accept T, SLOT_DONE T+1, REDIRECT T+2.
- CMP_SIGNED is valid from cycle T+1 until the cycle state returns to IDLE.
- Timeout: accept T, no CMP_VALID in T+1..T+CMP_TIMEOUT; ERR high in T+CMP_TIMEOUT+1 with state IDLE.
- Throughput: at most one branch in flight; back-to-back branches are separated by ≥1 IDLE cycle.

## Test plan
- Reset behaviour: assert RST_N low mid-WAIT_SLOT. Required: all outputs at reset values asynchronously, BR_READY=1 after release, no REDIRECT.
- BEQ taken: BR_PC=0x00400000, OFFSET=0x0003, CMP_VALID+EQUAL=1 and SLOT_DONE in T+1. Required: REDIRECT=1, REDIRECT_PC=0x00400010 in T+2 only.
- BLT, slot before compare: SLOT_DONE in T+1, CMP_VALID with SMALL=1 in T+4. Required: CMP_SIGNED=1 in T+1..T+4 and REDIRECT in T+5.
- BLT, not-taken variant: same sequence with SMALL=0. Required: no REDIRECT, IDLE in T+5.
- Offset wrap: BR_PC=0xFFFFFFF8, OFFSET=0x0001 → REDIRECT_PC=0x00000000. OFFSET=0xFFFF, BR_PC=0 → REDIRECT_PC=0x00000000.
- Timeout boundary, CMP_TIMEOUT=15: no CMP_VALID. Required: ERR pulse in T+16, BUSY=0 in T+16. CMP_VALID in T+15 instead: no ERR, normal resolution.
- FLUSH cases:
  - FLUSH coincident with CMP_VALID in WAIT_CMP: IDLE next cycle, no REDIRECT/ERR.
  - FLUSH with BR_VALID in IDLE: BR_READY=0, request not latched.
